// File: rtl/fifo_pkg.sv
// Shared types and sizing for the word-to-byte drain stage.
// Default word width, byte count and FSM state encoding.
package fifo_pkg;

  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_drain_word_shifter.sv
// Word holding register that presents one byte at a time.
// Shifts by a byte per accepted handshake, either end first.
module word_shifter #(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        dout
);

  logic [DATA_W-1:0] sr;

  // Load a fresh word, or move the next byte into the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= MSB_FIRST ? (sr << 8) : (sr >> 8);
    end
  end

  assign dout = MSB_FIRST ? sr[DATA_W-1 -: 8] : sr[7:0];

endmodule

// File: rtl/fifo_byte_drain.sv
// Reads words from the buffer and streams them out as bytes.
// One read in flight at most; back-to-back reads on the last byte.
module fifo_byte_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W     = fifo_pkg::DATA_W,
  parameter int RD_LATENCY = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Empty,
  input  logic [DATA_W-1:0] Dataout,
  output logic              Rden,
  input  logic              Flush,
  output logic [7:0]        Byte_out,
  output logic              Byte_valid,
  input  logic              Byte_ready,
  output logic              Busy,
  output logic [CNT_W-1:0]  Words_done
);

  localparam int BPW = DATA_W / 8;
  localparam int IW  = idx_w(BPW);

  localparam logic [1:0]    LAT  = 2'(RD_LATENCY);
  localparam logic [IW-1:0] LAST = IW'(BPW - 1);

  state_t        state;
  state_t        state_n;
  logic [1:0]    lat_cnt;
  logic [IW-1:0] byte_idx;
  logic          hs;
  logic          load;
  logic          shift;
  logic          done;

  assign hs = (state == SEND) && Byte_ready;

  // Next state plus shifter strobes; Flush overrides everything.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    if (Flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!Empty) state_n = WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT) begin
            state_n = SEND;
            load    = 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            shift = 1'b1;
            if (byte_idx == LAST) begin
              done    = 1'b1;
              state_n = Empty ? IDLE : WAIT;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_n;
  end

  // Read latency counter restarts on every entry into WAIT.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lat_cnt <= '0;
    end else if (state == WAIT && state_n == WAIT) begin
      lat_cnt <= lat_cnt + 2'd1;
    end else begin
      lat_cnt <= '0;
    end
  end

  // Byte position within the held word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      byte_idx <= '0;
    end else if (load) begin
      byte_idx <= '0;
    end else if (shift) begin
      byte_idx <= byte_idx + 1'b1;
    end
  end

  // Completed-word counter, free running modulo 2^CNT_W.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      Words_done <= '0;
    else if (done) Words_done <= Words_done + 1'b1;
  end

  word_shifter #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk  (Clk),
    .rst_n(Rst),
    .load (load),
    .shift(shift),
    .din  (Dataout),
    .dout (Byte_out)
  );

  assign Rden       = (state == WAIT) && (lat_cnt == 2'd0);
  assign Byte_valid = (state == SEND);
  assign Busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Bench for fifo_byte_drain: buffer model, byte monitor,
// and a queue-based reference of the expected byte stream.
module tb_fifo_byte_drain;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Flush = 1'b0;
  logic        Byte_ready = 1'b0;
  logic        Empty = 1'b1;
  logic [31:0] Dataout = '0;
  logic        Rden;
  logic        Byte_valid;
  logic        Busy;
  logic [7:0]  Byte_out;
  logic [15:0] Words_done;

  logic        rden2;
  logic        bv2;
  logic        busy2;
  logic [7:0]  bo2;
  logic [1:0]  wd2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] buf_q[$];
  logic [31:0] pend_word = '0;
  bit          rd_pend = 1'b0;
  int          underflow = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          rden_cnt = 0;
  int          dbl_err = 0;
  int          twin_err = 0;
  int          rden_t[$];
  bit          rden_prev = 1'b0;
  logic [1:0]  wd2_q[$];
  logic [1:0]  wd2_prev = '0;
  int          exp_wd = 0;

  localparam int PERIOD = 1 + 4 + 1;

  fifo_byte_drain #(
    .DATA_W(32), .RD_LATENCY(1), .MSB_FIRST(1'b1), .CNT_W(16)
  ) u_dut (
    .Clk(Clk), .Rst(Rst), .Empty(Empty), .Dataout(Dataout),
    .Rden(Rden), .Flush(Flush), .Byte_out(Byte_out),
    .Byte_valid(Byte_valid), .Byte_ready(Byte_ready),
    .Busy(Busy), .Words_done(Words_done)
  );

  fifo_byte_drain #(
    .DATA_W(32), .RD_LATENCY(1), .MSB_FIRST(1'b1), .CNT_W(2)
  ) u_wrap (
    .Clk(Clk), .Rst(Rst), .Empty(Empty), .Dataout(Dataout),
    .Rden(rden2), .Flush(Flush), .Byte_out(bo2),
    .Byte_valid(bv2), .Byte_ready(Byte_ready),
    .Busy(busy2), .Words_done(wd2)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  // Buffer model: data appears one cycle after the Rden cycle,
  // garbage otherwise.
  always @(negedge Clk) begin
    if (!Rst) begin
      buf_q.delete();
      rd_pend = 1'b0;
      Dataout = $urandom;
    end else begin
      if (rd_pend) Dataout = pend_word;
      else         Dataout = $urandom;
      rd_pend = 1'b0;
      if (Rden) begin
        if (buf_q.size() == 0) begin
          underflow++;
        end else begin
          pend_word = buf_q.pop_front();
          rd_pend = 1'b1;
        end
      end
    end
    Empty = (buf_q.size() == 0);
  end

  // Monitor: records handshaken bytes, read strobes, narrow counter.
  always @(negedge Clk) begin
    if (rden2 !== Rden || bv2 !== Byte_valid ||
        bo2 !== Byte_out || busy2 !== Busy)
      twin_err++;
    if (!Rst) begin
      rden_prev = 1'b0;
      wd2_prev = '0;
    end else begin
      if (Rden) begin
        rden_cnt++;
        rden_t.push_back(cyc);
        if (rden_prev) dbl_err++;
      end
      rden_prev = Rden;
      if (Byte_valid && Byte_ready && !Flush)
        rx_q.push_back(Byte_out);
      if (wd2 !== wd2_prev) wd2_q.push_back(wd2);
      wd2_prev = wd2;
    end
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    logic [31:0] t;
    t = w >> (8 * (3 - b));
    return t[7:0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    buf_q.push_back(w);
    for (int b = 0; b < 4; b++) exp_q.push_back(byte_of(w, b));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (!Busy && Empty && buf_q.size() == 0) ok = 1'b1;
      else begin @(negedge Clk); #1; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s idle_timeout busy=%b required 0", tag, Busy);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk); #1;
      if (rx_q.size() >= n) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s rx_timeout got=%0d required=%0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int r0;
    int base;
    repeat (3) @(negedge Clk);
    #1;
    vectors++;
    if (Rden !== 1'b0 || Byte_valid !== 1'b0 || Busy !== 1'b0 ||
        Words_done !== 16'd0 || Byte_out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%b%b%b/%h/%h required 000/0000/00",
               Rden, Byte_valid, Busy, Words_done, Byte_out);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    Byte_ready = 1'b1;
    r0 = rden_cnt;
    repeat (20) @(negedge Clk);
    #1;
    vectors++;
    if (rden_cnt !== r0) begin
      miscompares++;
      $display("FAIL reset_idle_rden got=%0d required=%0d", rden_cnt - r0, 0);
    end
    base = rx_q.size();
    @(posedge Clk); #1;
    push_word($urandom);
    push_word($urandom);
    wait_rx(base + 5, 40, "reset_midsend");
    vectors++;
    if (Words_done !== 16'd1 || Byte_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre got=%h/%b required 0001/1", Words_done, Byte_valid);
    end
    #1;
    Rst = 1'b0;
    #1;
    vectors++;
    if (Rden !== 1'b0 || Byte_valid !== 1'b0 || Busy !== 1'b0 ||
        Words_done !== 16'd0 || Byte_out !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_async got=%b%b%b/%h/%h required 000/0000/00",
               Rden, Byte_valid, Busy, Words_done, Byte_out);
    end
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b1;
    exp_wd = 0;
    exp_q.delete();
  endtask

  task automatic test_single();
    int base;
    int r0;
    base = rx_q.size();
    r0 = rden_cnt;
    exp_q.delete();
    @(posedge Clk); #1;
    push_word(32'h14);
    exp_wd++;
    wait_idle(60, "single");
    vectors++;
    if (rx_q.size() - base !== 4) begin
      miscompares++;
      $display("FAIL single_len got=%0d required=4", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (rx_q[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL single_byte%0d got=%h required=%h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (rden_cnt - r0 !== 1 || Words_done !== 16'(exp_wd) || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_misc got=%0d/%h/%b required 1/%h/0",
               rden_cnt - r0, Words_done, Busy, 16'(exp_wd));
    end
  endtask

  task automatic test_burst();
    int base;
    int r0;
    int t0;
    logic [31:0] words[5];
    words = '{32'd20, 32'd10, 32'd30, 32'd40, 32'd50};
    base = rx_q.size();
    r0 = rden_cnt;
    t0 = rden_t.size();
    exp_q.delete();
    Byte_ready = 1'b1;
    @(posedge Clk); #1;
    foreach (words[i]) push_word(words[i]);
    exp_wd += 5;
    wait_idle(80, "burst");
    vectors++;
    if (rx_q.size() - base !== 20) begin
      miscompares++;
      $display("FAIL burst_len got=%0d required=20", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 20; i++) begin
        vectors++;
        if (rx_q[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL burst_byte%0d got=%h required=%h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (rden_cnt - r0 !== 5) begin
      miscompares++;
      $display("FAIL burst_rden got=%0d required=5", rden_cnt - r0);
    end else begin
      for (int i = 1; i < 5; i++) begin
        vectors++;
        if (rden_t[t0+i] - rden_t[t0+i-1] !== PERIOD) begin
          miscompares++;
          $display("FAIL burst_period%0d got=%0d required=%0d", i,
                   rden_t[t0+i] - rden_t[t0+i-1], PERIOD);
        end
      end
    end
    vectors++;
    if (Words_done !== 16'(exp_wd) || underflow !== 0 || dbl_err !== 0) begin
      miscompares++;
      $display("FAIL burst_misc got=%h/%0d/%0d required %h/0/0",
               Words_done, underflow, dbl_err, 16'(exp_wd));
    end
  endtask

  task automatic test_backpressure();
    int base;
    int r0;
    logic [7:0] held;
    base = rx_q.size();
    exp_q.delete();
    Byte_ready = 1'b1;
    @(posedge Clk); #1;
    push_word(32'd10);
    push_word($urandom);
    exp_wd += 2;
    held = exp_q[2];
    wait_rx(base + 2, 40, "bp_start");
    @(posedge Clk); #1;
    Byte_ready = 1'b0;
    r0 = rden_cnt;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk); #1;
      vectors++;
      if (Byte_valid !== 1'b1 || Byte_out !== held) begin
        miscompares++;
        $display("FAIL bp_hold%0d got=%b/%h required 1/%h", i, Byte_valid, Byte_out, held);
      end
    end
    vectors++;
    if (rden_cnt !== r0) begin
      miscompares++;
      $display("FAIL bp_rden got=%0d required=0", rden_cnt - r0);
    end
    @(posedge Clk); #1;
    Byte_ready = 1'b1;
    wait_idle(60, "bp");
    vectors++;
    if (rx_q.size() - base !== 8) begin
      miscompares++;
      $display("FAIL bp_len got=%0d required=8", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (rx_q[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL bp_byte%0d got=%h required=%h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (Words_done !== 16'(exp_wd)) begin
      miscompares++;
      $display("FAIL bp_words got=%h required=%h", Words_done, 16'(exp_wd));
    end
  endtask

  task automatic test_flush();
    int base;
    logic [15:0] wd0;
    base = rx_q.size();
    exp_q.delete();
    Byte_ready = 1'b1;
    @(posedge Clk); #1;
    buf_q.push_back(32'd30);
    exp_q.push_back(byte_of(32'd30, 0));
    push_word(32'd40);
    wait_rx(base + 1, 40, "flush_start");
    @(posedge Clk); #1;
    wd0 = Words_done;
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    vectors++;
    if (Byte_valid !== 1'b0 || Rden !== 1'b0 || Words_done !== wd0) begin
      miscompares++;
      $display("FAIL flush_next got=%b/%b/%h required 0/0/%h",
               Byte_valid, Rden, Words_done, wd0);
    end
    exp_wd++;
    wait_idle(60, "flush");
    vectors++;
    if (rx_q.size() - base !== 5) begin
      miscompares++;
      $display("FAIL flush_len got=%0d required=5", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (rx_q[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL flush_byte%0d got=%h required=%h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (Words_done !== 16'(exp_wd)) begin
      miscompares++;
      $display("FAIL flush_words got=%h required=%h", Words_done, 16'(exp_wd));
    end
  endtask

  task automatic test_random();
    int base;
    int r0;
    int left;
    base = rx_q.size();
    r0 = rden_cnt;
    exp_q.delete();
    left = 12;
    for (int c = 0; c < 400 && left > 0; c++) begin
      @(posedge Clk); #1;
      Byte_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        push_word($urandom);
        left--;
      end
    end
    exp_wd += 12 - left;
    @(posedge Clk); #1;
    Byte_ready = 1'b1;
    wait_idle(120, "random");
    vectors++;
    if (rx_q.size() - base !== exp_q.size()) begin
      miscompares++;
      $display("FAIL random_len got=%0d required=%0d", rx_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rx_q[base+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random_byte%0d got=%h required=%h", i, rx_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (rden_cnt - r0 !== exp_q.size() / 4 || Words_done !== 16'(exp_wd) ||
        underflow !== 0 || dbl_err !== 0) begin
      miscompares++;
      $display("FAIL random_misc got=%0d/%h/%0d/%0d required %0d/%h/0/0",
               rden_cnt - r0, Words_done, underflow, dbl_err,
               exp_q.size() / 4, 16'(exp_wd));
    end
  endtask

  task automatic test_wrap();
    int w0;
    logic [1:0] want;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b1;
    exp_wd = 0;
    exp_q.delete();
    Byte_ready = 1'b1;
    w0 = wd2_q.size();
    @(posedge Clk); #1;
    for (int i = 0; i < 5; i++) push_word($urandom);
    exp_wd = 5;
    wait_idle(80, "wrap");
    vectors++;
    if (wd2_q.size() - w0 !== 5) begin
      miscompares++;
      $display("FAIL wrap_len got=%0d required=5", wd2_q.size() - w0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = 2'((i + 1) % 4);
        vectors++;
        if (wd2_q[w0+i] !== want) begin
          miscompares++;
          $display("FAIL wrap_seq%0d got=%0d required=%0d", i, wd2_q[w0+i], want);
        end
      end
    end
    vectors++;
    if (Words_done !== 16'(exp_wd) || twin_err !== 0) begin
      miscompares++;
      $display("FAIL wrap_misc got=%h/%0d required %h/0", Words_done, twin_err, 16'(exp_wd));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
